// File: rtl/bc6502_bus_pkg.sv
// Shared types and address map for the bc6502 memory bus controller.
// Optional I/O window support is enabled with BC6502_BUSCTL_IO_EN.
package bc6502_bus_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_ROM,
    REG_IO
  } region_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT
`ifdef BC6502_BUSCTL_IO_EN
    , S_IOWAIT
`endif
  } state_t;

  localparam int          RAM_ROM_BIT = 15;
  localparam logic [15:0] IO_BASE     = 16'h7F00;
  localparam logic [15:0] IO_MASK     = 16'hFF00;

endpackage

// File: rtl/bc6502_addr_dec.sv
// Combinational address decoder: CPU address to region and raw chip enables.
// The $7Fxx I/O window only exists when BC6502_BUSCTL_IO_EN is defined.
module bc6502_addr_dec
  import bc6502_bus_pkg::*;
(
  input  logic [15:0] addr_i,
  output region_t     region_o,
  output logic        ram_ce_n_o,
  output logic        rom_ce_n_o,
  output logic        io_ce_n_o
);

  // Only the upper address bits take part in decoding; the rest go straight to the devices.
  logic [15:0] unused_addr;
  assign unused_addr = addr_i;

  always_comb begin
    region_o = addr_i[RAM_ROM_BIT] ? REG_ROM : REG_RAM;
`ifdef BC6502_BUSCTL_IO_EN
    if ((addr_i & IO_MASK) == IO_BASE) begin
      region_o = REG_IO;
    end
`endif
  end

  assign ram_ce_n_o = (region_o != REG_RAM);
  assign rom_ce_n_o = (region_o != REG_ROM);
  assign io_ce_n_o  = (region_o != REG_IO);

endmodule

// File: rtl/bc6502_busctl.sv
// Bus controller between the bc6502 core and external ROM/RAM, inserting wait states.
// Define BC6502_BUSCTL_IO_EN to enable the handshaked I/O window with timeout.
module bc6502_busctl
  import bc6502_bus_pkg::*;
#(
  parameter int ROM_WS     = 1,
  parameter int RAM_WS     = 0,
  parameter int IO_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_ma,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_do,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_di,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d_o,
  output logic        mem_d_oe,
  input  logic [7:0]  mem_d_i,
  output logic        ram_ce_n,
  output logic        rom_ce_n,
  output logic        io_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  input  logic        io_ack,
  output logic        io_err
);

`ifdef BC6502_BUSCTL_IO_EN
  localparam int CNT_W = 8;
`else
  localparam int CNT_W = 4;
  logic [8:0] unused_io;
  assign unused_io = {io_ack, 8'(IO_TIMEOUT)};
`endif

  region_t          region;
  logic             ram_ce_raw, rom_ce_raw, io_ce_raw;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ws;
  logic             rdy;
  logic             timeout;

  bc6502_addr_dec u_dec (
    .addr_i     (cpu_ma),
    .region_o   (region),
    .ram_ce_n_o (ram_ce_raw),
    .rom_ce_n_o (rom_ce_raw),
    .io_ce_n_o  (io_ce_raw)
  );

  assign ws = (region == REG_ROM) ? CNT_W'(ROM_WS) : CNT_W'(RAM_WS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy     = 1'b1;
    timeout = 1'b0;
    case (state_q)
      S_RUN: begin
`ifdef BC6502_BUSCTL_IO_EN
        if (region == REG_IO) begin
          rdy     = 1'b0;
          cnt_d   = CNT_W'(IO_TIMEOUT - 1);
          state_d = S_IOWAIT;
        end else
`endif
        if (ws != '0) begin
          rdy     = 1'b0;
          cnt_d   = ws - 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rdy = (cnt_q == '0);
        if (rdy) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef BC6502_BUSCTL_IO_EN
      S_IOWAIT: begin
        rdy     = io_ack | (cnt_q == '0);
        timeout = ~io_ack & (cnt_q == '0);
        if (rdy) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every strobe is gated by reset so nothing is selected while the core is held.
  assign cpu_rdy  = ~reset_n | rdy;
  assign mem_a    = cpu_ma;
  assign mem_d_o  = cpu_do;
  assign mem_d_oe = reset_n & ~cpu_rw;
  assign mem_oe_n = ~(reset_n & cpu_rw);
  assign mem_we_n = ~(reset_n & ~cpu_rw & rdy);
  assign ram_ce_n = ~reset_n | ram_ce_raw;
  assign rom_ce_n = ~reset_n | rom_ce_raw;
`ifdef BC6502_BUSCTL_IO_EN
  assign io_ce_n  = ~reset_n | io_ce_raw;
  assign io_err   = reset_n & timeout;
`else
  assign io_ce_n  = 1'b1;
  assign io_err   = 1'b0;
  logic unused_io_ce;
  assign unused_io_ce = io_ce_raw;
`endif
  assign cpu_di   = !cpu_rw ? 8'h00 : (timeout ? 8'hFF : mem_d_i);

endmodule

// File: tb/tb_bc6502_busctl.sv
// Self-checking bench for bc6502_busctl: directed scenarios plus random accesses
// against a cycle-count model of the wait-state rules and shadow memories.
module tb_bc6502_busctl;

  localparam int ROM_WS = 3;
  localparam int RAM_WS = 0;
  localparam int IO_TO  = 8;
`ifdef BC6502_BUSCTL_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_ma = 16'h0000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_do = 8'h00;
  logic        io_ack = 1'b0;
  logic [7:0]  mem_d_i;
  logic        cpu_rdy, mem_d_oe, ram_ce_n, rom_ce_n, io_ce_n, mem_oe_n, mem_we_n, io_err;
  logic [7:0]  cpu_di, mem_d_o;
  logic [15:0] mem_a;

  int vec_cnt = 0;
  int err_cnt = 0;

  bit [7:0] dev_ram [32768];
  bit       dev_vld [32768];
  bit [7:0] ref_ram [32768];
  bit       ref_vld [32768];

  bc6502_busctl #(.ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .IO_TIMEOUT(IO_TO)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_ma(cpu_ma), .cpu_rw(cpu_rw), .cpu_do(cpu_do),
    .cpu_rdy(cpu_rdy), .cpu_di(cpu_di), .mem_a(mem_a), .mem_d_o(mem_d_o),
    .mem_d_oe(mem_d_oe), .mem_d_i(mem_d_i), .ram_ce_n(ram_ce_n), .rom_ce_n(rom_ce_n),
    .io_ce_n(io_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .io_ack(io_ack),
    .io_err(io_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] rom_val(input logic [12:0] a);
    return (a[7:0] * 8'd3) ^ {3'b000, a[12:8]} ^ 8'h96;
  endfunction

  function automatic logic [7:0] io_val(input logic [7:0] a);
    return ~a;
  endfunction

  // Device models: async ROM, RAM written on a low write strobe, simple I/O register file.
  always_comb begin
    if (!rom_ce_n)      mem_d_i = rom_val(mem_a[12:0]);
    else if (!io_ce_n)  mem_d_i = io_val(mem_a[7:0]);
    else if (!ram_ce_n) mem_d_i = dev_vld[mem_a[14:0]] ? dev_ram[mem_a[14:0]] : pat(mem_a[14:0]);
    else                mem_d_i = 8'hEE;
  end

  always @(posedge clk) begin
    if (reset_n && !ram_ce_n && !mem_we_n) begin
      dev_ram[mem_a[14:0]] <= mem_d_o;
      dev_vld[mem_a[14:0]] <= 1'b1;
    end
  end

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    if (a[15]) return rom_val(a[12:0]);
    if (IO_EN && a[14:8] == 7'h7F) return io_val(a[7:0]);
    return ref_vld[a[14:0]] ? ref_ram[a[14:0]] : pat(a[14:0]);
  endfunction

  // One CPU access: the expected length follows from the region's wait count
  // (or the I/O ack/timeout rule), checked cycle by cycle. Entered just after a rising edge.
  task automatic do_access(input logic [15:0] a, input logic rw, input logic [7:0] d,
                           input int ack_at, input string name);
    bit is_rom, is_io, to, last;
    int n;
    logic       exp_rdy, exp_err;
    logic [2:0] exp_ce, exp_str;
    logic [7:0] exp_di;
    is_rom = a[15];
    is_io  = IO_EN && !a[15] && (a[14:8] == 7'h7F);
    to     = 1'b0;
    if (is_io) begin
      if (ack_at == 0 || ack_at > IO_TO + 1) begin
        n  = IO_TO + 1;
        to = 1'b1;
      end else begin
        n = (ack_at < 2) ? 2 : ack_at;
      end
    end else begin
      n = (is_rom ? ROM_WS : RAM_WS) + 1;
    end
    cpu_ma = a; cpu_rw = rw; cpu_do = d;
    for (int k = 1; k <= n; k++) begin
      io_ack = (ack_at != 0) && (k >= ack_at);
      last = (k == n);
      @(negedge clk);
      exp_rdy = last;
      exp_ce  = {is_rom || is_io, !is_rom, !is_io};
      exp_str = {~rw, !(!rw && last), ~rw};
      exp_err = to && last;
      exp_di  = !rw ? 8'h00 : ((to && last) ? 8'hFF : exp_read(a));
      vec_cnt++;
      if (cpu_rdy !== exp_rdy) begin
        err_cnt++;
        $display("FAIL %s rdy cyc%0d: got %b want %b", name, k, cpu_rdy, exp_rdy);
      end
      vec_cnt++;
      if ({ram_ce_n, rom_ce_n, io_ce_n} !== exp_ce) begin
        err_cnt++;
        $display("FAIL %s ce{ram,rom,io} cyc%0d: got %b want %b", name, k,
                 {ram_ce_n, rom_ce_n, io_ce_n}, exp_ce);
      end
      vec_cnt++;
      if ({mem_oe_n, mem_we_n, mem_d_oe} !== exp_str) begin
        err_cnt++;
        $display("FAIL %s strobes{oe_n,we_n,d_oe} cyc%0d: got %b want %b", name, k,
                 {mem_oe_n, mem_we_n, mem_d_oe}, exp_str);
      end
      vec_cnt++;
      if (cpu_di !== exp_di) begin
        err_cnt++;
        $display("FAIL %s cpu_di cyc%0d: got %h want %h", name, k, cpu_di, exp_di);
      end
      vec_cnt++;
      if (io_err !== exp_err) begin
        err_cnt++;
        $display("FAIL %s io_err cyc%0d: got %b want %b", name, k, io_err, exp_err);
      end
      vec_cnt++;
      if ({mem_a, mem_d_o} !== {a, d}) begin
        err_cnt++;
        $display("FAIL %s addr/data cyc%0d: got %h/%h want %h/%h", name, k, mem_a, mem_d_o, a, d);
      end
      @(posedge clk);
      #1;
    end
    io_ack = 1'b0;
    if (!rw && !is_rom && !is_io) begin
      ref_ram[a[14:0]] = d;
      ref_vld[a[14:0]] = 1'b1;
    end
    $display("%s: addr=%h rw=%b data=%h ack_at=%0d cycles=%0d", name, a, rw, d, ack_at, n);
  endtask

  task automatic check_in_reset(input string name);
    @(negedge clk);
    vec_cnt++;
    if ({ram_ce_n, rom_ce_n, io_ce_n, mem_oe_n, mem_we_n} !== 5'b11111) begin
      err_cnt++;
      $display("FAIL %s enables: got %b want 11111", name,
               {ram_ce_n, rom_ce_n, io_ce_n, mem_oe_n, mem_we_n});
    end
    vec_cnt++;
    if ({cpu_rdy, mem_d_oe, io_err} !== 3'b100) begin
      err_cnt++;
      $display("FAIL %s rdy/d_oe/io_err: got %b want 100", name, {cpu_rdy, mem_d_oe, io_err});
    end
  endtask

  task automatic test_reset();
    cpu_ma = 16'h0020; cpu_rw = 1'b0; cpu_do = 8'h77; reset_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      check_in_reset("reset_initial");
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    // Abort a ROM access after one wait cycle.
    cpu_ma = 16'h8123; cpu_rw = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      check_in_reset("reset_mid_access");
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_access(16'h8123, 1'b1, 8'h00, 0, "reset_release_rom_read");
  endtask

  task automatic test_rom_read();
    do_access(16'h8005, 1'b1, 8'h00, 0, "rom_read_8005");
    do_access(16'hA005, 1'b1, 8'h00, 0, "rom_read_mirror_a005");
  endtask

  task automatic test_ram_write();
    do_access(16'h0010, 1'b0, 8'hA5, 0, "ram_write_0010");
    do_access(16'h0010, 1'b1, 8'h00, 0, "ram_readback_0010");
    do_access(16'h8010, 1'b0, 8'h5A, 0, "rom_write_setup");
  endtask

  task automatic test_back_to_back();
    do_access(16'h0042, 1'b1, 8'h00, 0, "b2b_ram_read");
    do_access(16'hFFFC, 1'b1, 8'h00, 0, "b2b_rom_read_fffc");
    do_access(16'h0043, 1'b0, 8'h3E, 0, "b2b_ram_write");
  endtask

  task automatic test_io();
    do_access(16'h7F02, 1'b1, 8'h00, 4, "io_read_ack4");
    do_access(16'h7F00, 1'b1, 8'h00, 0, "io_read_timeout");
    do_access(16'h7F05, 1'b1, 8'h00, 1, "io_read_early_ack");
    do_access(16'h7F01, 1'b0, 8'hC3, 0, "io_write_timeout");
    do_access(16'h7F01, 1'b1, 8'h00, 9, "io_read_ack_at_last");
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 16'($urandom_range(0, 63));
        1:       a = 16'h8000 | 16'($urandom_range(0, 32767));
        2:       a = 16'h7F00 | 16'($urandom_range(0, 255));
        default: a = 16'($urandom_range(0, 65535));
      endcase
      rw = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      do_access(a, rw, d, $urandom_range(0, 11), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rom_read();
    test_ram_write();
    test_back_to_back();
    test_io();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
